a_buffer_loader: RTL and testbench

Fills the per-row activation RAMs of the A-side input buffer from the PS-visible BRAM ahead of each systolic-array tile. On `start`, the block reads packed activation words from BRAM and unpacks them one element per cycle. It then scatters each element into the row RAM selected by a one-hot write enable, driving the buffer's `bram_to_ram_w_*` write port. It sits directly upstream of the A buffer; the buffer's address generator consumes the data once `done` pulses.

---
 rtl/a_buffer_loader_pkg.sv | 22 ++
 rtl/a_buffer_loader_word_unpacker.sv | 36 +++
 rtl/a_buffer_loader.sv | 194 +++++++++++++++++++
 tb/tb_a_buffer_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/a_buffer_loader_pkg.sv
// Shared definitions for the A-buffer loader: FSM encoding and word geometry.
package a_buffer_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_UNPACK,
    ST_DONE
  } state_e;

  // Activations packed per BRAM word.
  function automatic int calc_apw(input int data_w, input int act_w);
    return data_w / act_w;
  endfunction

  // A word must hold a whole number of activations, and at least one.
  function automatic bit width_ok(input int data_w, input int act_w);
    return (act_w > 0) && (data_w >= act_w) && ((data_w % act_w) == 0);
  endfunction

endpackage

// File: rtl/a_buffer_loader_word_unpacker.sv
// Holds one BRAM word and selects a single activation lane from it.
// While loading, the lane mux looks straight through to the incoming word so
// lane 0 can be registered downstream on the same edge the word is captured.
module word_unpacker
  import a_buffer_loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACT_W  = 8,
  parameter int LANE_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [LANE_W-1:0] lane_i,
  output logic [ACT_W-1:0]  lane_data_o
);

  localparam int APW = calc_apw(DATA_W, ACT_W);

  logic [DATA_W-1:0]           word_q;
  logic [APW-1:0][ACT_W-1:0]   lanes;

  // Word register, refreshed in the LATCH cycle.
  always_ff @(posedge clk) begin
    if (reset)       word_q <= '0;
    else if (load_i) word_q <= rdata_i;
  end

  // Lane mux over the word that will be held during the next UNPACK cycle.
  always_comb begin
    lanes       = load_i ? rdata_i : word_q;
    lane_data_o = lanes[lane_i];
  end

endmodule

// File: rtl/a_buffer_loader.sv
// Copies activation rows from the PS-visible BRAM into the A-buffer row RAMs,
// one element per cycle, ahead of each systolic-array tile.
module a_buffer_loader
  import a_buffer_loader_pkg::*;
#(
  parameter int RAM_SIZE        = 1024,
  parameter int ADDR_WIDTH      = $clog2(RAM_SIZE),
  parameter int ARRAY_N         = 8,
  parameter int ACT_WIDTH       = 8,
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int BRAM_DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [BRAM_ADDR_WIDTH-1:0]   src_base_addr,
  input  logic [BRAM_ADDR_WIDTH-1:0]   row_stride,
  input  logic [ADDR_WIDTH-1:0]        dst_base_addr,
  input  logic [$clog2(ARRAY_N):0]     num_rows,
  input  logic [ADDR_WIDTH:0]          num_cols,
  output logic                         bram_en,
  output logic [BRAM_ADDR_WIDTH-1:0]   bram_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]   bram_rdata,
  output logic [ADDR_WIDTH-1:0]        bram_to_ram_w_addr,
  output logic [ARRAY_N-1:0]           bram_to_ram_w_en,
  output logic [ACT_WIDTH-1:0]         bram_to_ram_w_data,
  output logic                         busy,
  output logic                         done
);

  localparam int APW    = calc_apw(BRAM_DATA_WIDTH, ACT_WIDTH);
  localparam int LANE_W = (APW > 1) ? $clog2(APW) : 1;
  localparam int ROW_W  = $clog2(ARRAY_N) + 1;
  localparam int COL_W  = ADDR_WIDTH + 1;
  localparam int BAW    = BRAM_ADDR_WIDTH;

  if (!width_ok(BRAM_DATA_WIDTH, ACT_WIDTH)) begin : g_bad_width
    $error("BRAM_DATA_WIDTH must be an integer multiple of ACT_WIDTH");
  end

  state_e                state_q, state_d;
  logic [ROW_W-1:0]      row_q, row_d, nrows_q, nrows_d, nrows_clamp;
  logic [COL_W-1:0]      col_q, col_d, ncols_q, ncols_d, ncols_clamp;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [BAW-1:0]        waddr_q, waddr_d, rowaddr_q, rowaddr_d, stride_q, stride_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;

  logic                  bram_en_q, bram_en_d, busy_q, busy_d, done_q, done_d;
  logic [BAW-1:0]        bram_addr_q, bram_addr_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [ARRAY_N-1:0]    w_en_q, w_en_d;
  logic [ACT_WIDTH-1:0]  w_data_q, w_data_d, lane_data;
  logic                  last_col, last_row, last_lane, wr;

  word_unpacker #(
    .DATA_W (BRAM_DATA_WIDTH),
    .ACT_W  (ACT_WIDTH),
    .LANE_W (LANE_W)
  ) u_unpack (
    .clk         (clk),
    .reset       (reset),
    .load_i      (state_q == ST_LATCH),
    .rdata_i     (bram_rdata),
    .lane_i      (lane_d),
    .lane_data_o (lane_data)
  );

  // Sequencing: latch the job on start, then walk rows / words / lanes.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    lane_d    = lane_q;
    waddr_d   = waddr_q;
    rowaddr_d = rowaddr_q;
    nrows_d   = nrows_q;
    ncols_d   = ncols_q;
    stride_d  = stride_q;
    dst_d     = dst_q;

    nrows_clamp = (num_rows > ROW_W'(ARRAY_N)) ? ROW_W'(ARRAY_N) : num_rows;
    ncols_clamp = (num_cols > COL_W'(RAM_SIZE)) ? COL_W'(RAM_SIZE) : num_cols;
    last_col    = (col_q == ncols_q - COL_W'(1));
    last_row    = (row_q == nrows_q - ROW_W'(1));
    last_lane   = (lane_q == LANE_W'(APW - 1));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          nrows_d   = nrows_clamp;
          ncols_d   = ncols_clamp;
          stride_d  = row_stride;
          dst_d     = dst_base_addr;
          row_d     = '0;
          col_d     = '0;
          lane_d    = '0;
          waddr_d   = src_base_addr;
          rowaddr_d = src_base_addr;
          state_d   = (nrows_clamp == '0 || ncols_clamp == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ:  state_d = ST_LATCH;
      ST_LATCH: state_d = ST_UNPACK;
      ST_UNPACK: begin
        if (last_col) begin
          if (last_row) begin
            state_d = ST_DONE;
          end else begin
            row_d     = row_q + ROW_W'(1);
            col_d     = '0;
            lane_d    = '0;
            rowaddr_d = rowaddr_q + stride_q;
            waddr_d   = rowaddr_q + stride_q;
            state_d   = ST_READ;
          end
        end else begin
          col_d = col_q + COL_W'(1);
          if (last_lane) begin
            lane_d  = '0;
            waddr_d = waddr_q + BAW'(1);
            state_d = ST_READ;
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the
  // state they belong to without any input-to-output combinational path.
  always_comb begin
    wr          = (state_d == ST_UNPACK);
    bram_en_d   = (state_d == ST_READ);
    bram_addr_d = bram_en_d ? waddr_d : '0;
    w_en_d      = wr ? (ARRAY_N'(1) << row_d) : '0;
    w_addr_d    = wr ? (dst_d + col_d[ADDR_WIDTH-1:0]) : '0;
    w_data_d    = wr ? lane_data : '0;
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      lane_q      <= '0;
      waddr_q     <= '0;
      rowaddr_q   <= '0;
      nrows_q     <= '0;
      ncols_q     <= '0;
      stride_q    <= '0;
      dst_q       <= '0;
      bram_en_q   <= 1'b0;
      bram_addr_q <= '0;
      w_en_q      <= '0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      lane_q      <= lane_d;
      waddr_q     <= waddr_d;
      rowaddr_q   <= rowaddr_d;
      nrows_q     <= nrows_d;
      ncols_q     <= ncols_d;
      stride_q    <= stride_d;
      dst_q       <= dst_d;
      bram_en_q   <= bram_en_d;
      bram_addr_q <= bram_addr_d;
      w_en_q      <= w_en_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bram_en            = bram_en_q;
  assign bram_addr          = bram_addr_q;
  assign bram_to_ram_w_en   = w_en_q;
  assign bram_to_ram_w_addr = w_addr_q;
  assign bram_to_ram_w_data = w_data_q;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule

// File: tb/tb_a_buffer_loader.sv
// Bench for a_buffer_loader: table of load jobs, BRAM model, write scoreboard,
// plus hand-built sequences for start-while-busy and reset mid-load.
module tb_a_buffer_loader;

  localparam int APW = 4;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [14:0] src_base_addr, row_stride;
  logic [9:0]  dst_base_addr;
  logic [3:0]  num_rows;
  logic [10:0] num_cols;
  logic        bram_en;
  logic [14:0] bram_addr;
  logic [31:0] bram_rdata;
  logic [9:0]  bram_to_ram_w_addr;
  logic [7:0]  bram_to_ram_w_en;
  logic [7:0]  bram_to_ram_w_data;
  logic        busy, done;

  a_buffer_loader dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .src_base_addr      (src_base_addr),
    .row_stride         (row_stride),
    .dst_base_addr      (dst_base_addr),
    .num_rows           (num_rows),
    .num_cols           (num_cols),
    .bram_en            (bram_en),
    .bram_addr          (bram_addr),
    .bram_rdata         (bram_rdata),
    .bram_to_ram_w_addr (bram_to_ram_w_addr),
    .bram_to_ram_w_en   (bram_to_ram_w_en),
    .bram_to_ram_w_data (bram_to_ram_w_data),
    .busy               (busy),
    .done               (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:32767];

  // One-cycle-latency BRAM read port.
  always @(posedge clk) if (bram_en) bram_rdata <= mem[bram_addr];

  typedef struct {
    logic [14:0] src;
    logic [14:0] stride;
    logic [9:0]  dst;
    logic [3:0]  nr;
    logic [10:0] nc;
    int          exp_cycles;
    int          exp_reads;
  } vec_t;

  typedef struct {
    logic [7:0] wen;
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  vec_t vecs [8];
  wr_t  sb [$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Independent model of the write stream a job should produce.
  task automatic push_expect(input vec_t v);
    int nr, nc;
    logic [14:0] wa;
    logic [31:0] w;
    wr_t e;
    nr = (v.nr > 8) ? 8 : int'(v.nr);
    nc = (v.nc > 1024) ? 1024 : int'(v.nc);
    for (int r = 0; r < nr; r++) begin
      for (int k = 0; k < nc; k++) begin
        wa     = 15'(int'(v.src) + r * int'(v.stride) + k / APW);
        w      = mem[wa];
        e.wen  = 8'(1 << r);
        e.addr = 10'(int'(v.dst) + k);
        e.data = w[8*(k%APW) +: 8];
        sb.push_back(e);
      end
    end
  endtask

  // Advance one cycle, sample at the falling edge, score any write seen.
  task automatic step();
    wr_t e;
    @(negedge clk);
    if (bram_to_ram_w_en !== 8'h00) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: w_en=%0h addr=%0d data=%0h, expected no write",
                 bram_to_ram_w_en, bram_to_ram_w_addr, bram_to_ram_w_data);
      end else begin
        e = sb.pop_front();
        check("w_en",   64'(bram_to_ram_w_en),   64'(e.wen));
        check("w_addr", 64'(bram_to_ram_w_addr), 64'(e.addr));
        check("w_data", 64'(bram_to_ram_w_data), 64'(e.data));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bram_en"},   64'(bram_en),            64'd0);
    check({tag, "_bram_addr"}, 64'(bram_addr),          64'd0);
    check({tag, "_w_addr"},    64'(bram_to_ram_w_addr), 64'd0);
    check({tag, "_w_en"},      64'(bram_to_ram_w_en),   64'd0);
    check({tag, "_w_data"},    64'(bram_to_ram_w_data), 64'd0);
    check({tag, "_busy"},      64'(busy),               64'd0);
    check({tag, "_done"},      64'(done),               64'd0);
  endtask

  task automatic drive(input vec_t v);
    src_base_addr = v.src;
    row_stride    = v.stride;
    dst_base_addr = v.dst;
    num_rows      = v.nr;
    num_cols      = v.nc;
  endtask

  // Run one job; poke_a/poke_b raise start with junk inputs in those cycles.
  task automatic run_load(input vec_t v, input int poke_a, input int poke_b);
    int cyc, done_at, busy_n, reads;
    cyc = 0; done_at = 0; busy_n = 0; reads = 0;
    drive(v);
    push_expect(v);
    start = 1'b1;
    do begin
      step();
      start = 1'b0;
      cyc++;
      if (busy)    busy_n++;
      if (bram_en) reads++;
      if (done)    done_at = cyc;
      if (cyc == poke_a || cyc == poke_b) begin
        start         = 1'b1;
        src_base_addr = 15'h1234;
        dst_base_addr = 10'd77;
        num_rows      = 4'd1;
        num_cols      = 11'd2;
      end
    end while (done_at == 0 && cyc < 5000);
    check("done_cycle",  64'(done_at), 64'(v.exp_cycles));
    check("busy_cycles", 64'(busy_n),  64'(v.exp_cycles));
    check("bram_reads",  64'(reads),   64'(v.exp_reads));
    step();
    start = 1'b0;
    check("idle_after_done", 64'(busy), 64'd0);
    check("writes_left", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    bit saw_done;
    for (int a = 0; a < 32768; a++) mem[a] = $urandom;
    mem[0] = 32'h04030201;
    mem[1] = 32'h08070605;

    //          src       stride  dst   nr  nc     cycles reads
    vecs[0] = '{15'd0,    15'd1,  10'd0,    4'd2,  11'd4,    13,   2};
    vecs[1] = '{15'd0,    15'd2,  10'd0,    4'd1,  11'd6,    11,   2};
    vecs[2] = '{15'd0,    15'd1,  10'd0,    4'd0,  11'd4,     1,   0};
    vecs[3] = '{15'd0,    15'd1,  10'd0,    4'd3,  11'd0,     1,   0};
    vecs[4] = '{15'd100,  15'd3,  10'd1022, 4'd12, 11'd4,    49,   8};
    vecs[5] = '{15'h7FFE, 15'd16, 10'd5,    4'd3,  11'd9,    46,   9};
    vecs[6] = '{15'd40,   15'd1,  10'd3,    4'd1,  11'd1500, 1537, 256};
    vecs[7] = '{15'd9,    15'd7,  10'd0,    4'd8,  11'd1,    25,   8};

    reset = 1'b1;
    start = 1'b0;
    drive(vecs[0]);
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_load(vecs[i], 0, 0);

    // start during UNPACK and during DONE are ignored; next IDLE start is taken.
    run_load(vecs[0], 4, 13);
    run_load(vecs[1], 0, 0);

    // Reset in the third UNPACK cycle aborts the job with no done pulse.
    drive(vecs[0]);
    push_expect(vecs[0]);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      start = 1'b0;
    end
    check("rst_midload_writes_before", 64'(sb.size()), 64'd5);
    reset = 1'b1;
    step();
    check_all_zero("rst_midload");
    sb.delete();
    reset = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    check("rst_midload_no_done", 64'(saw_done), 64'd0);

    run_load(vecs[0], 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
